// File: rtl/inference_sequencer_pkg.sv
// Shared definitions for the digit-inference datapath: sequencer states,
// class count and the packed score-vector width used by network and argmax.
package inference_sequencer_pkg;

  localparam int unsigned NUM_CLASSES = 10;
  localparam int unsigned DIGIT_W     = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NN_RUN = 3'd1,
    AM_RUN = 3'd2,
    RESULT = 3'd3,
    ERROR  = 3'd4
  } state_t;

  // Width of the packed vector carrying all class scores.
  function automatic int unsigned scores_width(input int unsigned width);
    return NUM_CLASSES * width;
  endfunction

endpackage

// File: rtl/inference_sequencer_watchdog_counter.sv
// Per-operation watchdog: counts enabled cycles since the last clear and
// raises expired once TIMEOUT_CYCLES-1 enabled cycles have elapsed.
module watchdog_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  // Count up while enabled; saturate once expired so the flag holds.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (enable && !expired) begin
      count   <= count + CW'(1);
      expired <= (count == CW'(TIMEOUT_CYCLES - 2));
    end
  end

endmodule

// File: rtl/inference_sequencer.sv
// Controller for one handwritten-digit inference: start the network, capture
// its scores, run argmax, hold the digit until acknowledged. A watchdog guards
// both sub-operations and one request may queue behind a busy inference.
module inference_sequencer
  import inference_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             req,
  output logic                             busy,
  output logic                             nn_start,
  input  logic                             nn_done,
  input  logic [scores_width(WIDTH)-1:0]   nn_scores,
  output logic                             argmax_start,
  output logic [scores_width(WIDTH)-1:0]   argmax_nums,
  input  logic                             argmax_done,
  input  logic [DIGIT_W-1:0]               argmax_digit,
  output logic                             result_valid,
  output logic [DIGIT_W-1:0]               result_digit,
  output logic                             error,
  input  logic                             result_ack,
  output logic [CNT_WIDTH-1:0]             infer_count
);

  localparam int unsigned SCORES_W = scores_width(WIDTH);

  state_t                 state, state_d;
  logic                   pending, pending_d;
  logic                   busy_d, nn_start_d, argmax_start_d;
  logic                   result_valid_d, error_d;
  logic [DIGIT_W-1:0]     result_digit_d;
  logic [SCORES_W-1:0]    argmax_nums_d;
  logic [CNT_WIDTH-1:0]   infer_count_d;
  logic                   wd_clear, wd_enable, wd_expired;

  watchdog_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // State register plus all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      pending      <= 1'b0;
      busy         <= 1'b0;
      nn_start     <= 1'b0;
      argmax_start <= 1'b0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      result_digit <= '0;
      argmax_nums  <= '0;
      infer_count  <= '0;
    end else begin
      state        <= state_d;
      pending      <= pending_d;
      busy         <= busy_d;
      nn_start     <= nn_start_d;
      argmax_start <= argmax_start_d;
      result_valid <= result_valid_d;
      error        <= error_d;
      result_digit <= result_digit_d;
      argmax_nums  <= argmax_nums_d;
      infer_count  <= infer_count_d;
    end
  end

  // Next-state and next-output logic; a done pulse beats watchdog expiry.
  always_comb begin
    state_d        = state;
    pending_d      = pending;
    nn_start_d     = 1'b0;
    argmax_start_d = 1'b0;
    result_valid_d = result_valid;
    error_d        = error;
    result_digit_d = result_digit;
    argmax_nums_d  = argmax_nums;
    infer_count_d  = infer_count;
    wd_clear       = 1'b0;

    // A request arriving while busy queues one deep; extras are absorbed.
    if ((state != IDLE) && req) begin
      pending_d = 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (req || pending) begin
          state_d    = NN_RUN;
          pending_d  = 1'b0;
          nn_start_d = 1'b1;
          wd_clear   = 1'b1;
        end
      end
      NN_RUN: begin
        if (nn_done) begin
          argmax_nums_d  = nn_scores;
          argmax_start_d = 1'b1;
          state_d        = AM_RUN;
          wd_clear       = 1'b1;
        end else if (wd_expired) begin
          state_d        = ERROR;
          result_valid_d = 1'b1;
          error_d        = 1'b1;
        end
      end
      AM_RUN: begin
        if (argmax_done) begin
          result_digit_d = argmax_digit;
          result_valid_d = 1'b1;
          error_d        = 1'b0;
          infer_count_d  = infer_count + CNT_WIDTH'(1);
          state_d        = RESULT;
        end else if (wd_expired) begin
          state_d        = ERROR;
          result_valid_d = 1'b1;
          error_d        = 1'b1;
        end
      end
      RESULT: begin
        if (result_ack) begin
          result_valid_d = 1'b0;
          state_d        = IDLE;
        end
      end
      ERROR: begin
        if (result_ack) begin
          result_valid_d = 1'b0;
          error_d        = 1'b0;
          state_d        = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d    = (state_d != IDLE);
    wd_enable = (state == NN_RUN) || (state == AM_RUN);
  end

endmodule

// File: tb/tb_inference_sequencer.sv
// Randomized self-checking bench for inference_sequencer with a
// transaction-level model of requests, queueing, timeouts and results.
module tb_inference_sequencer;

  localparam int unsigned W  = 32;
  localparam int unsigned T  = 32;
  localparam int unsigned CW = 4;
  localparam int unsigned NC = 10;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              req;
  logic              busy;
  logic              nn_start;
  logic              nn_done;
  logic [NC*W-1:0]   nn_scores;
  logic              argmax_start;
  logic [NC*W-1:0]   argmax_nums;
  logic              argmax_done;
  logic [3:0]        argmax_digit;
  logic              result_valid;
  logic [3:0]        result_digit;
  logic              error;
  logic              result_ack;
  logic [CW-1:0]     infer_count;

  always #5 clk = ~clk;

  inference_sequencer #(
    .WIDTH(W), .TIMEOUT_CYCLES(T), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .busy(busy),
    .nn_start(nn_start), .nn_done(nn_done), .nn_scores(nn_scores),
    .argmax_start(argmax_start), .argmax_nums(argmax_nums),
    .argmax_done(argmax_done), .argmax_digit(argmax_digit),
    .result_valid(result_valid), .result_digit(result_digit),
    .error(error), .result_ack(result_ack), .infer_count(infer_count)
  );

  int         total = 0;
  int         bad   = 0;
  int         exp_count = 0;
  bit         pend = 1'b0;
  logic [3:0] exp_digit = 4'd0;
  logic [W-1:0] sc [NC];

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] argmax_ref();
    int best = 0;
    for (int k = 1; k < NC; k++) if (sc[k] > sc[best]) best = k;
    return 4'(best);
  endfunction

  task automatic drive_scores();
    for (int k = 0; k < NC; k++) nn_scores[k*W +: W] = sc[k];
  endtask

  task automatic check_nums(input string tag);
    for (int k = 0; k < NC; k++) check_val(tag, argmax_nums[k*W +: W], sc[k]);
  endtask

  // Wait n cycles with optional background requests and spurious pulses.
  task automatic idle_ticks(input int n, input bit rnd_req, input bit spur_am,
                            input bit spur_nn, input int force_reqs);
    for (int i = 0; i < n; i++) begin
      if (i < force_reqs || (rnd_req && $urandom_range(0, 3) == 0)) begin
        req  = 1'b1;
        pend = 1'b1;
      end
      if (spur_am) begin
        argmax_done  = 1'b1;
        argmax_digit = 4'($urandom_range(0, 9));
        result_ack   = 1'b1;
      end
      if (spur_nn) begin
        nn_done = 1'b1;
        for (int k = 0; k < NC; k++) nn_scores[k*W +: W] = $urandom;
      end
      tick();
      req = 1'b0; argmax_done = 1'b0; nn_done = 1'b0; result_ack = 1'b0;
    end
  endtask

  task automatic do_ack();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    check_val("ack_valid", result_valid, 0);
    check_val("ack_error", error, 0);
    check_val("ack_busy", busy, 0);
    check_val("ack_nn_start", nn_start, 0);
    if (!pend) begin
      tick();
      check_val("idle_busy", busy, 0);
      check_val("idle_nn_start", nn_start, 0);
    end
  endtask

  task automatic check_error_state(input string tag);
    check_val({tag, "_error"}, error, 1);
    check_val({tag, "_valid"}, result_valid, 1);
    check_val({tag, "_busy"}, busy, 1);
    check_val({tag, "_digit"}, result_digit, exp_digit);
    check_val({tag, "_count"}, infer_count, exp_count);
  endtask

  // One inference; nn_lat/am_lat are done latencies in cycles after the start
  // edge, 0 meaning the unit never answers.
  task automatic run_txn(input int nn_lat, input int am_lat, input bit fixed,
                         input bit rnd_req, input bit spur, input int am_reqs,
                         input int hold);
    logic [3:0] dig;
    if (!pend) begin
      req = 1'b1; tick(); req = 1'b0;
    end else begin
      tick();
    end
    pend = 1'b0;
    check_val("start_busy", busy, 1);
    check_val("start_pulse", nn_start, 1);
    check_val("start_valid", result_valid, 0);
    tick();
    check_val("start_pulse_end", nn_start, 0);

    if (nn_lat == 0) begin
      idle_ticks(T - 2, rnd_req, spur, 1'b0, 0);
      check_val("nn_pre_timeout", result_valid, 0);
      tick();
      check_error_state("nn_timeout");
      do_ack();
      return;
    end

    idle_ticks(nn_lat - 2, rnd_req, spur, 1'b0, 0);
    check_val("nn_wait_valid", result_valid, 0);
    check_val("nn_wait_busy", busy, 1);
    if (!fixed) for (int k = 0; k < NC; k++) sc[k] = $urandom;
    drive_scores();
    nn_done = 1'b1;
    tick();
    nn_done = 1'b0;
    check_val("am_start", argmax_start, 1);
    check_val("am_no_error", error, 0);
    check_val("am_valid", result_valid, 0);
    check_nums("capture");

    if (am_lat == 0) begin
      idle_ticks(T - 1, rnd_req, 1'b0, 1'b0, am_reqs);
      tick();
      check_error_state("am_timeout");
      do_ack();
      return;
    end

    idle_ticks(am_lat - 1, rnd_req, 1'b0, 1'b0, am_reqs);
    check_val("am_wait_valid", result_valid, 0);
    dig = argmax_ref();
    argmax_digit = dig;
    argmax_done  = 1'b1;
    tick();
    argmax_done  = 1'b0;
    argmax_digit = 4'($urandom_range(0, 9));
    exp_count = (exp_count + 1) % (1 << CW);
    exp_digit = dig;
    check_val("res_valid", result_valid, 1);
    check_val("res_digit", result_digit, exp_digit);
    check_val("res_error", error, 0);
    check_val("res_count", infer_count, exp_count);
    check_val("res_busy", busy, 1);

    if (hold > 0) begin
      idle_ticks(hold, rnd_req, 1'b0, spur, 0);
      check_val("hold_valid", result_valid, 1);
      check_val("hold_digit", result_digit, exp_digit);
      check_nums("hold_nums");
    end
    do_ack();
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_nn_start"}, nn_start, 0);
    check_val({tag, "_am_start"}, argmax_start, 0);
    check_val({tag, "_valid"}, result_valid, 0);
    check_val({tag, "_error"}, error, 0);
    check_val({tag, "_digit"}, result_digit, 0);
    check_val({tag, "_count"}, infer_count, 0);
    check_val({tag, "_nums"}, argmax_nums, 0);
  endtask

  initial begin
    reset_n = 1'b0; req = 1'b0; nn_done = 1'b0; nn_scores = '0;
    argmax_done = 1'b0; argmax_digit = 4'd0; result_ack = 1'b0;
    tick(); tick();
    check_reset_state("reset");
    reset_n = 1'b1;
    tick();
    check_val("post_reset_busy", busy, 0);

    // Nominal: scores k*100 with class 7 dominant.
    for (int k = 0; k < NC; k++) sc[k] = W'(k * 100);
    sc[7] = W'(5000);
    run_txn(20, 6, 1'b1, 1'b0, 1'b0, 0, 0);
    check_val("nominal_digit_cnt", infer_count, 1);

    // Queued request plus an absorbed third one, then the pending run.
    run_txn(20, 6, 1'b0, 1'b0, 1'b0, 2, 0);
    run_txn(12, 6, 1'b0, 1'b0, 1'b0, 0, 0);
    tick();
    check_val("absorbed_busy", busy, 0);
    check_val("two_runs_count", infer_count, 3);

    // Network timeout, done/expiry race, argmax timeout.
    run_txn(0, 6, 1'b0, 1'b0, 1'b0, 0, 0);
    run_txn(T, 6, 1'b0, 1'b0, 1'b0, 0, 0);
    run_txn(10, 0, 1'b0, 1'b0, 1'b0, 0, 0);

    // Spurious done and ack pulses outside their wait states.
    run_txn(15, 6, 1'b0, 1'b0, 1'b1, 0, 3);

    // Reset in the middle of AM_RUN, with a request pending.
    req = 1'b1; tick(); req = 1'b0;
    idle_ticks(4, 1'b0, 1'b0, 1'b0, 0);
    for (int k = 0; k < NC; k++) sc[k] = $urandom;
    drive_scores();
    nn_done = 1'b1; tick(); nn_done = 1'b0;
    req = 1'b1; tick(); req = 1'b0;
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    check_reset_state("midrst");
    argmax_digit = 4'd5; argmax_done = 1'b1; tick(); argmax_done = 1'b0;
    check_val("late_done_valid", result_valid, 0);
    check_val("late_done_busy", busy, 0);
    check_val("late_done_start", nn_start, 0);
    check_val("late_done_count", infer_count, 0);
    exp_count = 0; exp_digit = 4'd0; pend = 1'b0;

    // Randomized traffic; infer_count wraps along the way.
    for (int n = 0; n < 40; n++) begin
      int nl, al;
      nl = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, T));
      al = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 10));
      run_txn(nl, al, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              0, int'($urandom_range(0, 3)));
      if (!pend && $urandom_range(0, 1) == 1) idle_ticks(int'($urandom_range(1, 3)), 1'b0, 1'b0, 1'b0, 0);
    end
    if (pend) run_txn(8, 6, 1'b0, 1'b0, 1'b0, 0, 0);
    check_val("final_count", infer_count, exp_count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
